// File: rtl/tap_window_stats.sv
// -----------------------------------------------------------------------------
// tap_window_stats
//
// Purpose:
//   Window statistics for a 16-tap, 4-bit 2-D shift register. The flattened
//   tap bus is reduced through a 4-stage registered adder/max tree to produce
//   SUM, AVG (= SUM >> 4) and MAX. A hysteresis alarm FSM watches AVG.
//   Results are flagged valid only once the upstream window has been
//   completely refilled after reset (16 shifts).
//
// Optional feature:
//   `define TAP_WINDOW_MIN_EN adds output MIN (smallest tap), computed by a
//   minimum tree running alongside the maximum tree with identical latency,
//   hold behaviour and reset value.
//
// Ports:
//   CLK        in   1   system clock, rising edge
//   RESET_N    in   1   synchronous active-low reset
//   SHIFT_EN   in   1   TAPS holds a newly shifted window this cycle
//   TAPS       in  64   TAP_k at [4k+3:4k], TAP_0 newest
//   SUM        out  8   sum of all taps (0..240), held when not valid
//   AVG        out  4   SUM[7:4], held when not valid
//   MAX        out  4   largest tap, held when not valid
//   MIN        out  4   smallest tap (TAP_WINDOW_MIN_EN only)
//   OUT_VALID  out  1   SUM/AVG/MAX belong to a full window this cycle
//   ALARM      out  1   hysteresis alarm (registered decode of ALARM state)
//   DBG_STATE  out  2   alarm FSM state: 0 IDLE, 1 PENDING, 2 ALARM
//
// Handshake: OUT_VALID is a pure qualifier; there is no back-pressure. A
// result is consumed in the cycle OUT_VALID=1 or it is lost.
//
// Latency: TAPS in cycle n -> SUM/AVG/MAX/OUT_VALID in cycle n+4,
//          ALARM reacting to that result in cycle n+5.
// -----------------------------------------------------------------------------
module tap_window_stats #(
  parameter logic [3:0] HI_THRESH  = 4'd10,
  parameter logic [3:0] LO_THRESH  = 4'd5,
  parameter logic [3:0] HOLD_COUNT = 4'd3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        SHIFT_EN,
  input  logic [63:0] TAPS,
  output logic [7:0]  SUM,
  output logic [3:0]  AVG,
  output logic [3:0]  MAX,
`ifdef TAP_WINDOW_MIN_EN
  output logic [3:0]  MIN,
`endif
  output logic        OUT_VALID,
  output logic        ALARM,
  output logic [1:0]  DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_ALARM   = 2'd2
  } state_t;

  function automatic logic [3:0] max4(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [3:0] min4(input logic [3:0] a, input logic [3:0] b);
    return (a < b) ? a : b;
  endfunction

  // ---------------------------------------------------------------------------
  // Fill counter: counts shifts since reset, saturating at 16. The 16th shift
  // (counter already at 15) is the first one that presents a full window.
  // ---------------------------------------------------------------------------
  logic [4:0] fill;
  logic       qualify;

  assign qualify = SHIFT_EN && (fill >= 5'd15);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      fill <= '0;
    end else if (SHIFT_EN && (fill != 5'd16)) begin
      fill <= fill + 5'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: pairwise reduction straight off TAPS (8 x 5-bit sums, 8 maxima).
  // ---------------------------------------------------------------------------
  logic [4:0] s1_sum [8];
  logic [3:0] s1_max [8];
  logic       v1;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      v1 <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        s1_sum[i] <= '0;
        s1_max[i] <= '0;
      end
    end else begin
      v1 <= qualify;
      for (int i = 0; i < 8; i++) begin
        s1_sum[i] <= {1'b0, TAPS[8*i +: 4]} + {1'b0, TAPS[8*i+4 +: 4]};
        s1_max[i] <= max4(TAPS[8*i +: 4], TAPS[8*i+4 +: 4]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: 4 x 6-bit sums, 4 maxima.
  // ---------------------------------------------------------------------------
  logic [5:0] s2_sum [4];
  logic [3:0] s2_max [4];
  logic       v2;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      v2 <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        s2_sum[i] <= '0;
        s2_max[i] <= '0;
      end
    end else begin
      v2 <= v1;
      for (int i = 0; i < 4; i++) begin
        s2_sum[i] <= {1'b0, s1_sum[2*i]} + {1'b0, s1_sum[2*i+1]};
        s2_max[i] <= max4(s1_max[2*i], s1_max[2*i+1]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: 2 x 7-bit sums, 2 maxima.
  // ---------------------------------------------------------------------------
  logic [6:0] s3_sum [2];
  logic [3:0] s3_max [2];
  logic       v3;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      v3 <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        s3_sum[i] <= '0;
        s3_max[i] <= '0;
      end
    end else begin
      v3 <= v2;
      for (int i = 0; i < 2; i++) begin
        s3_sum[i] <= {1'b0, s2_sum[2*i]} + {1'b0, s2_sum[2*i+1]};
        s3_max[i] <= max4(s2_max[2*i], s2_max[2*i+1]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 4: final reduction into the output registers. The data outputs only
  // load when the travelling qualify bit is set, so gaps and the fill period
  // leave the last good result on the bus.
  // ---------------------------------------------------------------------------
  logic [7:0] sum_d;

  assign sum_d = {1'b0, s3_sum[0]} + {1'b0, s3_sum[1]};

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      SUM       <= '0;
      AVG       <= '0;
      MAX       <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= v3;
      if (v3) begin
        SUM <= sum_d;
        AVG <= sum_d[7:4];
        MAX <= max4(s3_max[0], s3_max[1]);
      end
    end
  end

`ifdef TAP_WINDOW_MIN_EN
  // ---------------------------------------------------------------------------
  // Minimum tree, stage-aligned with the maximum tree; shares v1..v3.
  // ---------------------------------------------------------------------------
  logic [3:0] s1_min [8];
  logic [3:0] s2_min [4];
  logic [3:0] s3_min [2];

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int i = 0; i < 8; i++) s1_min[i] <= '0;
      for (int i = 0; i < 4; i++) s2_min[i] <= '0;
      for (int i = 0; i < 2; i++) s3_min[i] <= '0;
      MIN <= '0;
    end else begin
      for (int i = 0; i < 8; i++) s1_min[i] <= min4(TAPS[8*i +: 4], TAPS[8*i+4 +: 4]);
      for (int i = 0; i < 4; i++) s2_min[i] <= min4(s1_min[2*i], s1_min[2*i+1]);
      for (int i = 0; i < 2; i++) s3_min[i] <= min4(s2_min[2*i], s2_min[2*i+1]);
      if (v3) begin
        MIN <= min4(s3_min[0], s3_min[1]);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Alarm FSM. Only moves on cycles carrying a valid result; hold counts
  // consecutive valid AVGs at or above HI_THRESH while PENDING.
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_d;
  logic [3:0] hold;
  logic [3:0] hold_d;
  logic [3:0] hold_inc;
  logic       alarm_d;

  // State register (also registers the ALARM decode).
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= S_IDLE;
      hold  <= '0;
      ALARM <= 1'b0;
    end else begin
      state <= state_d;
      hold  <= hold_d;
      ALARM <= alarm_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state;
    hold_d   = hold;
    hold_inc = hold + 4'd1;
    if (OUT_VALID) begin
      case (state)
        S_IDLE: begin
          if (AVG >= HI_THRESH) begin
            hold_d  = 4'd1;
            state_d = (HOLD_COUNT <= 4'd1) ? S_ALARM : S_PENDING;
          end
        end
        S_PENDING: begin
          if (AVG >= HI_THRESH) begin
            hold_d = hold_inc;
            if (hold_inc >= HOLD_COUNT) begin
              state_d = S_ALARM;
            end
          end else begin
            hold_d  = '0;
            state_d = S_IDLE;
          end
        end
        S_ALARM: begin
          if (AVG < LO_THRESH) begin
            hold_d  = '0;
            state_d = S_IDLE;
          end
        end
        default: begin
          hold_d  = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output decode. ALARM is registered from the next state so it tracks the
  // state register exactly, without a combinational path to the port.
  always_comb begin
    alarm_d   = (state_d == S_ALARM);
    DBG_STATE = state;
  end

endmodule

// File: tb/tb_tap_window_stats.sv
// -----------------------------------------------------------------------------
// tb_tap_window_stats
//
// Self-checking bench for tap_window_stats (default parameters 10/5/3).
// Directed scenarios check fixed expected values; random traffic is scored
// against a cycle-level behavioural model built from window arithmetic and a
// run-length hysteresis rule. Build with +define+TAP_WINDOW_MIN_EN to also
// exercise MIN.
// -----------------------------------------------------------------------------
module tb_tap_window_stats;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        SHIFT_EN = 1'b0;
  logic [63:0] TAPS = '0;
  logic [7:0]  SUM;
  logic [3:0]  AVG;
  logic [3:0]  MAX;
`ifdef TAP_WINDOW_MIN_EN
  logic [3:0]  MIN;
`endif
  logic        OUT_VALID;
  logic        ALARM;
  logic [1:0]  DBG_STATE;

  always #5 CLK = ~CLK;

  tap_window_stats dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .SHIFT_EN  (SHIFT_EN),
    .TAPS      (TAPS),
    .SUM       (SUM),
    .AVG       (AVG),
    .MAX       (MAX),
`ifdef TAP_WINDOW_MIN_EN
    .MIN       (MIN),
`endif
    .OUT_VALID (OUT_VALID),
    .ALARM     (ALARM),
    .DBG_STATE (DBG_STATE)
  );

  int n_checks = 0;
  int n_pass   = 0;

  localparam int HI = 10;
  localparam int LO = 5;
  localparam int HOLD = 3;
  localparam logic [63:0] ALL_F = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] RAMP  = 64'hFEDC_BA98_7654_3210;

  // ---------------------------------------------------------------------------
  // Reference model: tracks what each output should be in the current cycle.
  // A window submitted in cycle c shows up in cycle c+4; the alarm follows the
  // sequence of valid AVGs as a run-length rule.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit q;
    int sum;
    int mx;
    int mn;
  } ent_t;

  ent_t pipe_q[$];
  int   m_fill, m_run, m_sum, m_max, m_min;
  bit   m_valid, m_alarm;

  task automatic model_reset();
    ent_t z;
    z = '{q: 1'b0, sum: 0, mx: 0, mn: 0};
    pipe_q = {};
    for (int i = 0; i < 3; i++) pipe_q.push_back(z);
    m_fill = 0; m_run = 0; m_sum = 0; m_max = 0; m_min = 0;
    m_valid = 1'b0; m_alarm = 1'b0;
  endtask

  task automatic model_edge(input logic rst_n, input logic sh, input logic [63:0] taps);
    ent_t e, f;
    int   t;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_valid) begin
      if (m_alarm) begin
        if (m_sum / 16 < LO) begin m_alarm = 1'b0; m_run = 0; end
      end else if (m_sum / 16 >= HI) begin
        m_run++;
        if (m_run >= HOLD) m_alarm = 1'b1;
      end else begin
        m_run = 0;
      end
    end
    e.q = sh && (m_fill >= 15);
    e.sum = 0; e.mx = 0; e.mn = 15;
    for (int k = 0; k < 16; k++) begin
      t = int'(taps[4*k +: 4]);
      e.sum += t;
      if (t > e.mx) e.mx = t;
      if (t < e.mn) e.mn = t;
    end
    pipe_q.push_back(e);
    f = pipe_q.pop_front();
    m_valid = f.q;
    if (f.q) begin m_sum = f.sum; m_max = f.mx; m_min = f.mn; end
    if (sh && m_fill < 16) m_fill++;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: called at a falling edge, applies inputs for this cycle, lets the
  // rising edge happen, advances the model, and returns at the next falling
  // edge where outputs for the new cycle are stable.
  // ---------------------------------------------------------------------------
  task automatic step(input logic rst_n, input logic sh, input logic [63:0] taps);
    RESET_N  = rst_n;
    SHIFT_EN = sh;
    TAPS     = taps;
    @(posedge CLK);
    model_edge(rst_n, sh, taps);
    @(negedge CLK);
  endtask

  function automatic logic [63:0] flat(input logic [3:0] v);
    logic [63:0] r;
    for (int k = 0; k < 16; k++) r[4*k +: 4] = v;
    return r;
  endfunction

  function automatic logic [63:0] rand_taps(input int lvl);
    logic [63:0] r;
    int t;
    for (int k = 0; k < 16; k++) begin
      t = lvl + $urandom_range(0, 4) - 2;
      if (t < 0) t = 0;
      if (t > 15) t = 15;
      r[4*k +: 4] = 4'(t);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    step(1'b0, 1'b1, ALL_F);
    step(1'b0, 1'b0, '0);
    n_checks++;
    if ({SUM, AVG, MAX, OUT_VALID, ALARM} !== 18'd0)
      $display("FAIL reset_outputs: got sum=%0d avg=%0d max=%0d v=%0b a=%0b, expected all 0",
               SUM, AVG, MAX, OUT_VALID, ALARM);
    else n_pass++;
`ifdef TAP_WINDOW_MIN_EN
    n_checks++;
    if (MIN !== 4'd0) $display("FAIL reset_min: got %0d expected 0", MIN);
    else n_pass++;
`endif
  endtask

  // Reset, then all-0xF windows every clock: first valid in cycle 19, ALARM from 22.
  task automatic test_fill();
    int k;
    step(1'b0, 1'b0, '0);
    for (int c = 0; c < 24; c++) begin
      step(1'b1, 1'b1, ALL_F);
      k = c + 1;
      n_checks++;
      if (OUT_VALID !== (k >= 19)) $display("FAIL fill_valid c%0d: got %0b expected %0b", k, OUT_VALID, (k >= 19));
      else n_pass++;
      n_checks++;
      if (ALARM !== (k >= 22)) $display("FAIL fill_alarm c%0d: got %0b expected %0b", k, ALARM, (k >= 22));
      else n_pass++;
      if (k == 19) begin
        n_checks++;
        if (SUM !== 8'd240 || AVG !== 4'd15 || MAX !== 4'd15)
          $display("FAIL fill_first_result: got sum=%0d avg=%0d max=%0d expected 240/15/15", SUM, AVG, MAX);
        else n_pass++;
      end
    end
  endtask

  // Ramp TAP_k = k on a full window.
  task automatic test_ramp();
    for (int c = 0; c < 4; c++) step(1'b1, 1'b1, RAMP);
    n_checks++;
    if (OUT_VALID !== 1'b1 || SUM !== 8'd120 || AVG !== 4'd7 || MAX !== 4'd15)
      $display("FAIL ramp: got v=%0b sum=%0d avg=%0d max=%0d expected 1/120/7/15", OUT_VALID, SUM, AVG, MAX);
    else n_pass++;
`ifdef TAP_WINDOW_MIN_EN
    n_checks++;
    if (MIN !== 4'd0) $display("FAIL ramp_min: got %0d expected 0", MIN);
    else n_pass++;
`endif
  endtask

  // AVG sequence 10,10,10,6,5,4 lands on cycles 19..24 after reset.
  task automatic test_alarm_hysteresis();
    int lv [6] = '{10, 10, 10, 6, 5, 4};
    int k;
    logic exp;
    step(1'b0, 1'b0, '0);
    for (int c = 0; c < 28; c++) begin
      step(1'b1, 1'b1, (c >= 15 && c <= 20) ? flat(4'(lv[c-15])) : 64'd0);
      k = c + 1;
      exp = (k >= 22 && k <= 24);
      n_checks++;
      if (ALARM !== exp) $display("FAIL hyst_alarm c%0d: got %0b expected %0b", k, ALARM, exp);
      else n_pass++;
    end
  endtask

  // AVG sequence 10,10,9,10: the 9 breaks the run, alarm never rises.
  task automatic test_no_alarm();
    int lv [4] = '{10, 10, 9, 10};
    int k;
    step(1'b0, 1'b0, '0);
    for (int c = 0; c < 28; c++) begin
      step(1'b1, 1'b1, (c >= 15 && c <= 18) ? flat(4'(lv[c-15])) : 64'd0);
      k = c + 1;
      n_checks++;
      if (ALARM !== 1'b0) $display("FAIL no_alarm c%0d: got %0b expected 0", k, ALARM);
      else n_pass++;
    end
  endtask

  // SHIFT_EN low for cycles 25..27 -> OUT_VALID low for 29..31, data held.
  task automatic test_gap();
    int k;
    logic exp_v;
    logic [7:0] held_sum;
    logic [3:0] held_avg, held_max;
    step(1'b0, 1'b0, '0);
    for (int c = 0; c < 40; c++) begin
      step(1'b1, !(c >= 25 && c <= 27), rand_taps($urandom_range(0, 15)));
      k = c + 1;
      exp_v = (k >= 19) && !(k >= 29 && k <= 31);
      n_checks++;
      if (OUT_VALID !== exp_v) $display("FAIL gap_valid c%0d: got %0b expected %0b", k, OUT_VALID, exp_v);
      else n_pass++;
      if (k == 28) begin held_sum = SUM; held_avg = AVG; held_max = MAX; end
      if (k >= 29 && k <= 31) begin
        n_checks++;
        if (SUM !== held_sum || AVG !== held_avg || MAX !== held_max)
          $display("FAIL gap_hold c%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                   k, SUM, AVG, MAX, held_sum, held_avg, held_max);
        else n_pass++;
      end
      n_checks++;
      if (SUM !== 8'(m_sum)) $display("FAIL gap_sum_model c%0d: got %0d expected %0d", k, SUM, m_sum);
      else n_pass++;
    end
  endtask

  // Reset while ALARM=1 and pipeline full; refill needs 16 fresh shifts.
  task automatic test_reset_mid();
    int k;
    step(1'b0, 1'b0, '0);
    for (int c = 0; c < 25; c++) step(1'b1, 1'b1, ALL_F);
    n_checks++;
    if (ALARM !== 1'b1 || OUT_VALID !== 1'b1)
      $display("FAIL midrst_pre: got alarm=%0b valid=%0b expected 1/1", ALARM, OUT_VALID);
    else n_pass++;
    step(1'b0, 1'b1, ALL_F);
    n_checks++;
    if ({SUM, AVG, MAX, OUT_VALID, ALARM} !== 18'd0)
      $display("FAIL midrst_clear: got sum=%0d avg=%0d max=%0d v=%0b a=%0b expected all 0",
               SUM, AVG, MAX, OUT_VALID, ALARM);
    else n_pass++;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 1'b1, ALL_F);
      k = c + 1;
      n_checks++;
      if (OUT_VALID !== (k >= 19)) $display("FAIL midrst_valid c%0d: got %0b expected %0b", k, OUT_VALID, (k >= 19));
      else n_pass++;
    end
  endtask

  // Random traffic with gaps and occasional resets, scored against the model.
  task automatic test_random();
    int lvl = 8;
    logic rn, sh;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) lvl = $urandom_range(0, 15);
      rn = ($urandom_range(0, 249) != 0);
      sh = ($urandom_range(0, 7) != 0);
      step(rn, sh, rand_taps(lvl));
      n_checks++;
      if (OUT_VALID !== m_valid) $display("FAIL rnd_valid c%0d: got %0b expected %0b", c, OUT_VALID, m_valid);
      else n_pass++;
      n_checks++;
      if (ALARM !== m_alarm) $display("FAIL rnd_alarm c%0d: got %0b expected %0b", c, ALARM, m_alarm);
      else n_pass++;
      n_checks++;
      if (SUM !== 8'(m_sum) || AVG !== 4'(m_sum / 16) || MAX !== 4'(m_max))
        $display("FAIL rnd_data c%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                 c, SUM, AVG, MAX, m_sum, m_sum / 16, m_max);
      else n_pass++;
`ifdef TAP_WINDOW_MIN_EN
      n_checks++;
      if (MIN !== 4'(m_min)) $display("FAIL rnd_min c%0d: got %0d expected %0d", c, MIN, m_min);
      else n_pass++;
`endif
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    @(negedge CLK);
    test_reset();
    test_fill();
    test_ramp();
    test_alarm_hysteresis();
    test_no_alarm();
    test_gap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion before 200000");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule
